// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX encoder and the RX decoder.
// Holds the shifter state encoding, the frame geometry constants and the
// default baud divider, so both ends of the link agree on the bit rate.
package uart_pkg;

  // Shifter states
  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS      = 8;
  localparam int unsigned UART_BYTES_PER_WORD = 4;
  localparam int unsigned UART_FRAME_BITS     = 10;  // start + 8 data + stop

  // 50 MHz / 115200 baud
  localparam int unsigned UART_CLK_DIV_DEFAULT = 434;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud-rate tick generator.
// Counts 0..CLK_DIV-1 and asserts tick during the final count; the count
// then wraps to 0. clear forces the next count back to 0 so the caller can
// restart bit timing on any state entry.
// Ports:
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   clear - restart the count on the next edge
//   tick  - high during the last cycle of a bit period
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_CLK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  // 16 bits covers the full legal divider range, including CLK_DIV = 1.
  localparam logic [15:0] LastCount = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LastCount);

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_encode.sv
// UART transmitter: serialises 32-bit words as four 8N1 frames,
// least-significant byte first and LSB-first within each byte.
// A one-word holding register lets the next word queue while the current
// one shifts out; a queued word starts with no idle gap.
// Ports:
//   clk    - system clock
//   rst    - asynchronous active-high reset (aborts any frame in flight)
//   din    - word to transmit
//   dvalid - din valid
//   dready - holding register empty; transfer on dvalid && dready
//   tx     - registered UART serial output, idles high
//   busy   - a word is held or being shifted
module uart_encode
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = UART_CLK_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] din,
  input  logic        dvalid,
  output logic        dready,
  output logic        tx,
  output logic        busy
);

  localparam logic [2:0] LastBit  = 3'(UART_DATA_BITS - 1);
  localparam logic [1:0] LastByte = 2'(UART_BYTES_PER_WORD - 1);

  uart_state_e state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic [31:0] shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        tx_q, tx_d;
  logic [7:0]  cur_byte;
  logic        tick;
  logic        clear;
  logic        accept;

  uart_baud_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clear(clear),
    .tick (tick)
  );

  assign accept = dvalid && !hold_full_q;
  assign dready = !hold_full_q;
  assign busy   = hold_full_q || (state_q != StIdle);
  assign tx     = tx_q;

  // Hold the counter at 0 while idle and restart it on every state entry.
  assign clear = (state_q == StIdle) || (state_d != state_q);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;

    // Accept and reload are mutually exclusive: accept needs hold empty,
    // reload needs hold full.
    if (accept) begin
      hold_d      = din;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          byte_cnt_d  = '0;
          state_d     = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (tick) begin
          if (bit_cnt_q == LastBit) begin
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (byte_cnt_q != LastByte) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {8'h00, shift_q[31:8]};
            state_d    = StStart;
          end else if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            byte_cnt_d  = '0;
            state_d     = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // tx is computed from next-state values so the pin changes on the same
  // edge as the state and stays glitch-free.
  assign cur_byte = shift_d[7:0];

  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = cur_byte[bit_cnt_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      tx_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      tx_q        <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_encode.sv
// Directed bench for uart_encode: one instance at CLK_DIV=4, one at CLK_DIV=1.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_encode;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din_a, din_b;
  logic        dvalid_a, dvalid_b;
  logic        dready_a, tx_a, busy_a;
  logic        dready_b, tx_b, busy_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_encode #(
    .CLK_DIV(4)
  ) dut_a (
    .clk   (clk),
    .rst   (rst),
    .din   (din_a),
    .dvalid(dvalid_a),
    .dready(dready_a),
    .tx    (tx_a),
    .busy  (busy_a)
  );

  uart_encode #(
    .CLK_DIV(1)
  ) dut_b (
    .clk   (clk),
    .rst   (rst),
    .din   (din_b),
    .dvalid(dvalid_b),
    .dready(dready_b),
    .tx    (tx_b),
    .busy  (busy_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected line level for frame-bit index f of a word (10 bits per byte).
  function automatic logic exp_bit(input logic [31:0] w, input int f);
    int byte_i;
    int pos;
    byte_i = f / 10;
    pos    = f % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return w[byte_i * 8 + pos - 1];
  endfunction

  // Check tx every cycle for cycle offsets first..last after tx fell.
  // Entered and left on a falling edge.
  task automatic check_word(input string tag, input logic [31:0] w, input int div,
                            input int first, input int last, input bit scramble);
    for (int i = first; i <= last; i++) begin
      check_eq(tag, {31'b0, (div == 1) ? tx_b : tx_a}, {31'b0, exp_bit(w, i / div)});
      if (scramble) din_a = $urandom();
      @(negedge clk);
    end
  endtask

  task automatic send_a(input logic [31:0] w);
    int i;
    din_a    = w;
    dvalid_a = 1'b1;
    i = 0;
    while (!dready_a && i < 1000) begin
      @(negedge clk);
      i++;
    end
    check_eq("send dready", {31'b0, dready_a}, 32'd1);
    @(negedge clk);
    dvalid_a = 1'b0;
  endtask

  // Independent receiver: finds each start bit, samples mid-bit at CLK_DIV=4.
  task automatic rx_word(output logic [31:0] w);
    logic [7:0] b;
    int         i;
    w = '0;
    for (int byte_i = 0; byte_i < 4; byte_i++) begin
      i = 0;
      while (tx_a !== 1'b0 && i < 2000) begin
        @(negedge clk);
        i++;
      end
      check_eq("rx start found", {31'b0, tx_a}, 32'd0);
      repeat (2) @(negedge clk);
      check_eq("rx start mid", {31'b0, tx_a}, 32'd0);
      for (int k = 0; k < 8; k++) begin
        repeat (4) @(negedge clk);
        b[k] = tx_a;
      end
      repeat (4) @(negedge clk);
      check_eq("rx stop", {31'b0, tx_a}, 32'd1);
      w[byte_i*8 +: 8] = b;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r0, r1;
    rst      = 1'b1;
    din_a    = '0;
    din_b    = '0;
    dvalid_a = 1'b0;
    dvalid_b = 1'b0;
    @(negedge clk);
    check_eq("reset tx", {31'b0, tx_a}, 32'd1);
    check_eq("reset dready", {31'b0, dready_a}, 32'd1);
    check_eq("reset busy", {31'b0, busy_a}, 32'd0);
    check_eq("reset tx b", {31'b0, tx_b}, 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Single word
    din_a    = 32'hA5C3_0F81;
    dvalid_a = 1'b1;
    @(negedge clk);
    dvalid_a = 1'b0;
    check_eq("t1 dready held", {31'b0, dready_a}, 32'd0);
    check_eq("t1 busy held", {31'b0, busy_a}, 32'd1);
    check_eq("t1 tx before load", {31'b0, tx_a}, 32'd1);
    @(negedge clk);
    check_eq("t1 dready freed", {31'b0, dready_a}, 32'd1);
    check_word("t1 bit", 32'hA5C3_0F81, 4, 0, 158, 0);
    check_eq("t1 busy last", {31'b0, busy_a}, 32'd1);
    check_word("t1 bit", 32'hA5C3_0F81, 4, 159, 159, 0);
    check_eq("t1 busy end", {31'b0, busy_a}, 32'd0);
    check_eq("t1 tx end", {31'b0, tx_a}, 32'd1);

    // Back-to-back
    @(negedge clk);
    din_a    = 32'h1122_3344;
    dvalid_a = 1'b1;
    @(negedge clk);
    din_a = 32'h8899_AABB;
    check_eq("t2 dready full", {31'b0, dready_a}, 32'd0);
    @(negedge clk);
    check_eq("t2 dready freed", {31'b0, dready_a}, 32'd1);
    check_word("t2 w1 bit", 32'h1122_3344, 4, 0, 0, 0);
    dvalid_a = 1'b0;
    check_eq("t2 dready w2 held", {31'b0, dready_a}, 32'd0);
    check_word("t2 w1 bit", 32'h1122_3344, 4, 1, 159, 0);
    check_word("t2 w2 bit", 32'h8899_AABB, 4, 0, 159, 0);
    check_eq("t2 busy end", {31'b0, busy_a}, 32'd0);

    // Backpressure with din scrambled during the stall
    @(negedge clk);
    din_a    = 32'hCAFE_0001;
    dvalid_a = 1'b1;
    @(negedge clk);
    din_a = 32'h0BAD_F00D;
    @(negedge clk);
    check_word("t3 w1 bit", 32'hCAFE_0001, 4, 0, 0, 0);
    din_a = 32'h3C3C_9669;
    check_eq("t3 stall dready", {31'b0, dready_a}, 32'd0);
    check_word("t3 w1 bit", 32'hCAFE_0001, 4, 1, 159, 1);
    check_eq("t3 w3 dready", {31'b0, dready_a}, 32'd1);
    din_a = 32'h3C3C_9669;
    check_word("t3 w2 bit", 32'h0BAD_F00D, 4, 0, 0, 0);
    dvalid_a = 1'b0;
    din_a    = 32'hFFFF_FFFF;
    check_eq("t3 w3 held", {31'b0, dready_a}, 32'd0);
    check_word("t3 w2 bit", 32'h0BAD_F00D, 4, 1, 159, 0);
    check_word("t3 w3 bit", 32'h3C3C_9669, 4, 0, 159, 0);
    check_eq("t3 busy end", {31'b0, busy_a}, 32'd0);

    // Reset during DATA of byte 2
    @(negedge clk);
    din_a    = 32'h1234_5678;
    dvalid_a = 1'b1;
    @(negedge clk);
    dvalid_a = 1'b0;
    @(negedge clk);
    check_word("t4 pre bit", 32'h1234_5678, 4, 0, 89, 0);
    rst = 1'b1;
    #1;
    check_eq("t4 rst tx", {31'b0, tx_a}, 32'd1);
    check_eq("t4 rst dready", {31'b0, dready_a}, 32'd1);
    check_eq("t4 rst busy", {31'b0, busy_a}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t4 idle tx", {31'b0, tx_a}, 32'd1);
    check_eq("t4 idle busy", {31'b0, busy_a}, 32'd0);
    din_a    = 32'h0000_00FF;
    dvalid_a = 1'b1;
    @(negedge clk);
    dvalid_a = 1'b0;
    @(negedge clk);
    check_word("t4 post bit", 32'h0000_00FF, 4, 0, 159, 0);
    check_eq("t4 busy end", {31'b0, busy_a}, 32'd0);

    // Loopback through an independent receiver
    @(negedge clk);
    fork
      begin
        send_a(32'hDEAD_BEEF);
        send_a(32'h0000_0000);
      end
      begin
        rx_word(r0);
        rx_word(r1);
      end
    join
    check_eq("t5 loop w0", r0, 32'hDEAD_BEEF);
    check_eq("t5 loop w1", r1, 32'h0000_0000);
    repeat (4) @(negedge clk);
    check_eq("t5 busy end", {31'b0, busy_a}, 32'd0);

    // CLK_DIV = 1
    din_b    = 32'h5555_5555;
    dvalid_b = 1'b1;
    @(negedge clk);
    dvalid_b = 1'b0;
    @(negedge clk);
    check_word("t6 bit", 32'h5555_5555, 1, 0, 38, 0);
    check_eq("t6 busy last", {31'b0, busy_b}, 32'd1);
    check_word("t6 bit", 32'h5555_5555, 1, 39, 39, 0);
    check_eq("t6 busy end", {31'b0, busy_b}, 32'd0);
    check_eq("t6 tx end", {31'b0, tx_b}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
